// File: rtl/gen_multiport_fifo_pkg.sv
// -----------------------------------------------------------------------------
// gen_multiport_fifo_pkg
// Shared helpers for the multi-port FIFO slice:
//   - ptr_w()       : pointer width for a given address width (one wrap bit)
//   - therm_count() : number of asserted lanes in a thermometer vector
//   - is_therm()    : legality check for thermometer-coded lane requests
// Vectors wider than MAX_LANES are not supported by the helpers.
// -----------------------------------------------------------------------------
package gen_multiport_fifo_pkg;

  localparam int MAX_LANES = 32;

  // Pointers carry one extra MSB so full and empty remain distinguishable.
  function automatic int ptr_w(input int aw);
    return aw + 1;
  endfunction

  function automatic int unsigned therm_count(input logic [MAX_LANES-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < MAX_LANES; i++) begin
      n += 32'(v[i]);
    end
    return n;
  endfunction

  // A thermometer code from bit 0 has no set bit above a clear bit, which is
  // exactly when adding one clears every set bit.
  function automatic logic is_therm(input logic [MAX_LANES-1:0] v);
    return ((v + 1'b1) & v) == '0;
  endfunction

endpackage

// File: rtl/gen_multiport_fifo_if.sv
// -----------------------------------------------------------------------------
// gen_multiport_fifo_if
// Producer/consumer bundle of the multi-port FIFO.
//   master : drives flush, push_req, data_w, pop_req; observes the rest
//   slave  : the FIFO itself
// Push lane i occupies data_w[DW*i +: DW]; read lane j occupies
// data_r[DW*j +: DW] and holds the entry at head+j.
// -----------------------------------------------------------------------------
interface gen_multiport_fifo_if #(
  parameter int DW = 64,
  parameter int AW = 3,
  parameter int WP = 4,
  parameter int RP = 2
);

  logic             flush;
  logic [WP-1:0]    push_req;
  logic [DW*WP-1:0] data_w;
  logic             push_ack;
  logic [RP-1:0]    pop_req;
  logic [DW*RP-1:0] data_r;
  logic [RP-1:0]    data_r_vld;
  logic             fifo_empty;
  logic             fifo_full;
  logic [AW:0]      fifo_cnt;

  modport master (
    output flush, push_req, data_w, pop_req,
    input  push_ack, data_r, data_r_vld, fifo_empty, fifo_full, fifo_cnt
  );

  modport slave (
    input  flush, push_req, data_w, pop_req,
    output push_ack, data_r, data_r_vld, fifo_empty, fifo_full, fifo_cnt
  );

endinterface

// File: rtl/gen_multiport_fifo_therm_cnt.sv
// -----------------------------------------------------------------------------
// gen_therm_cnt
// Thermometer-to-binary lane count.
//   therm : W-bit thermometer vector (bit 0 first)
//   cnt   : number of asserted lanes, 0..W
// -----------------------------------------------------------------------------
module gen_therm_cnt
  import gen_multiport_fifo_pkg::*;
#(
  parameter int W  = 4,
  parameter int CW = $clog2(W + 1)
) (
  input  logic [W-1:0]  therm,
  output logic [CW-1:0] cnt
);

  always_comb begin
    cnt = CW'(therm_count(MAX_LANES'(therm)));
  end

endmodule

// File: rtl/gen_multiport_fifo.sv
// -----------------------------------------------------------------------------
// gen_multiport_fifo
// Multi-port FIFO over one circular store of 2**AW entries. Accepts 0..WP
// entries per cycle (all-or-nothing) and releases 0..RP entries per cycle.
// The head is shown first-word-fall-through with per-lane valid bits.
//   CLK  : clock, all state changes on the rising edge
//   RST  : synchronous active-high reset (same effect as flush)
//   bus  : slave side of gen_multiport_fifo_if (flush, push/pop lanes,
//          head data, push_ack, empty/full/occupancy status)
// -----------------------------------------------------------------------------
module gen_multiport_fifo
  import gen_multiport_fifo_pkg::*;
#(
  parameter int DW = 64,
  parameter int AW = 3,
  parameter int WP = 4,
  parameter int RP = 2
) (
  input  logic                  CLK,
  input  logic                  RST,
  gen_multiport_fifo_if.slave   bus
);

  localparam int DP  = 1 << AW;
  localparam int PW  = ptr_w(AW);
  localparam int PCW = $clog2(WP + 1);
  localparam int QCW = $clog2(RP + 1);

  logic [PW-1:0]  rd_ptr;
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  cnt;
  logic [PW-1:0]  free;
  logic [DW-1:0]  mem [DP];

  logic [PCW-1:0] n_push;
  logic [QCW-1:0] n_pop;
  logic [RP-1:0]  vld;
  logic [RP-1:0]  pop_eff;
  logic           push_ack;
  logic [DP-1:0]  we;
  logic [DW-1:0]  wdata [DP];

  gen_therm_cnt #(.W(WP), .CW(PCW)) u_push_cnt (
    .therm (bus.push_req),
    .cnt   (n_push)
  );

  gen_therm_cnt #(.W(RP), .CW(QCW)) u_pop_cnt (
    .therm (pop_eff),
    .cnt   (n_pop)
  );

  // Free space is taken from the registered count only, so a same-cycle pop
  // never credits a push and there is no pop_req -> push_ack path.
  always_comb begin
    free     = PW'(DP) - cnt;
    push_ack = (PW'(n_push) <= free) && !bus.flush;
  end

  // FWFT head: lane j shows entry head+j, valid while occupancy exceeds j.
  always_comb begin
    for (int j = 0; j < RP; j++) begin
      vld[j]                 = cnt > PW'(j);
      bus.data_r[DW*j +: DW] = mem[AW'(rd_ptr[AW-1:0] + AW'(j))];
    end
  end

  // Pops beyond the valid lanes are dropped here, which prevents underflow.
  assign pop_eff        = bus.pop_req & vld;
  assign bus.push_ack   = push_ack;
  assign bus.data_r_vld = vld;
  assign bus.fifo_empty = (cnt == '0);
  assign bus.fifo_full  = (free < PW'(WP));
  assign bus.fifo_cnt   = cnt;

  // Per-entry write decode: entry k takes lane i when k == wr_ptr+i (mod DP).
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    we = '0;
    for (int k = 0; k < DP; k++) begin
      wdata[k] = '0;
      for (int i = 0; i < WP; i++) begin
        if (push_ack && (i < int'(n_push)) &&
            ((wr_ptr[AW-1:0] + AW'(i)) == AW'(k))) begin
          we[k]    = 1'b1;
          wdata[k] = bus.data_w[DW*i +: DW];
        end
      end
    end
  end

  // NOTE: storage has no reset; stale contents are hidden by data_r_vld.
  always_ff @(posedge CLK) begin
    for (int k = 0; k < DP; k++) begin
      if (we[k]) mem[k] <= wdata[k];
    end
  end

  // Flush and reset share priority over push and pop. A push accepted in the
  // same cycle as RST wrote into mem, but the pointers discard it.
  always_ff @(posedge CLK) begin
    if (RST || bus.flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ack) wr_ptr <= wr_ptr + PW'(n_push);
      rd_ptr <= rd_ptr + PW'(n_pop);
      cnt    <= cnt + (push_ack ? PW'(n_push) : PW'(0)) - PW'(n_pop);
    end
  end

endmodule

// File: tb/tb_gen_multiport_fifo.sv
// -----------------------------------------------------------------------------
// tb_gen_multiport_fifo
// Directed and randomized stimulus for gen_multiport_fifo (DW=8, AW=3, WP=4,
// RP=2) checked against a queue-based reference model of the FIFO contents.
// -----------------------------------------------------------------------------
module tb_gen_multiport_fifo;
  import gen_multiport_fifo_pkg::*;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int WP = 4;
  localparam int RP = 2;
  localparam int DP = 8;

  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  gen_multiport_fifo_if #(.DW(DW), .AW(AW), .WP(WP), .RP(RP)) bus ();

  gen_multiport_fifo #(.DW(DW), .AW(AW), .WP(WP), .RP(RP)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [DW-1:0] q[$];
  int pushed_total = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive lanes, check pre-edge outputs against the model,
  // then advance the model across the edge. Called just after a falling edge.
  task automatic cycle(input int np, input int npop, input logic fl,
                       input logic rst, input logic [31:0] wdata);
    logic [WP-1:0] preq;
    logic [RP-1:0] qreq;
    int cnt;
    int npe;
    logic exp_ack;
    preq = WP'((1 << np) - 1);
    qreq = RP'((1 << npop) - 1);
    assert (is_therm(MAX_LANES'(preq)) && is_therm(MAX_LANES'(qreq)))
      else $error("illegal non-thermometer request");
    bus.push_req = preq;
    bus.pop_req  = qreq;
    bus.flush    = fl;
    bus.data_w   = wdata;
    RST          = rst;
    #1;
    cnt     = q.size();
    exp_ack = (np <= DP - cnt) && !fl;
    check("push_ack",   32'(bus.push_ack),   32'(exp_ack));
    check("fifo_cnt",   32'(bus.fifo_cnt),   32'(cnt));
    check("fifo_empty", 32'(bus.fifo_empty), 32'(cnt == 0));
    check("fifo_full",  32'(bus.fifo_full),  32'((DP - cnt) < WP));
    check("data_r_vld", 32'(bus.data_r_vld), {30'd0, cnt > 1, cnt > 0});
    for (int j = 0; j < RP; j++) begin
      if (j < cnt) check($sformatf("data_r%0d", j), 32'(bus.data_r[DW*j +: DW]), 32'(q[j]));
    end
    @(posedge CLK);
    if (fl || rst) begin
      q.delete();
    end else begin
      npe = (npop < cnt) ? npop : cnt;
      repeat (npe) void'(q.pop_front());
      if (exp_ack) begin
        for (int i = 0; i < np; i++) q.push_back(wdata[DW*i +: DW]);
        pushed_total += np;
      end
    end
    @(negedge CLK);
  endtask

  initial begin
    RST          = 1'b1;
    bus.flush    = 1'b0;
    bus.push_req = '0;
    bus.pop_req  = '0;
    bus.data_w   = '0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b0;

    // Idle after reset: empty, not full, ack for an empty request.
    cycle(0, 0, 1'b0, 1'b0, 32'h0);

    // Fill to 7, then a 2-lane push is refused, a 1-lane push fills to 8.
    cycle(4, 0, 1'b0, 1'b0, 32'h13121110);
    cycle(3, 0, 1'b0, 1'b0, 32'h00161514);
    check("cnt_after_7", 32'(bus.fifo_cnt), 32'd7);
    check("full_at_7",   32'(bus.fifo_full), 32'd1);
    cycle(2, 0, 1'b0, 1'b0, 32'h0000EEEE);
    check("cnt_hold_7",  32'(bus.fifo_cnt), 32'd7);
    cycle(1, 0, 1'b0, 1'b0, 32'h00000017);
    check("cnt_8",       32'(bus.fifo_cnt), 32'd8);

    // Full: pop two while pushing two -> push refused (no pop credit).
    cycle(2, 2, 1'b0, 1'b0, 32'h0000DDDD);
    check("head0_0x12",  32'(bus.data_r[7:0]),  32'h12);
    check("head1_0x13",  32'(bus.data_r[15:8]), 32'h13);
    check("cnt_6",       32'(bus.fifo_cnt), 32'd6);
    // At 6: pop two and push two together, both proceed.
    cycle(2, 2, 1'b0, 1'b0, 32'h00001918);
    check("cnt_6_again", 32'(bus.fifo_cnt), 32'd6);
    check("head0_0x14",  32'(bus.data_r[7:0]), 32'h14);

    // Randomized traffic across several pointer wraps.
    for (int t = 0; t < 90; t++) begin
      cycle(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'b0, 1'b0, $urandom);
      check("cnt_bound", 32'(bus.fifo_cnt <= 4'd8), 32'd1);
    end

    // Drain down to a single entry (bounded loop).
    for (int t = 0; t < 20 && q.size() > 1; t++) cycle(0, 1, 1'b0, 1'b0, 32'h0);
    if (q.size() == 0) cycle(1, 0, 1'b0, 1'b0, 32'h000000A5);
    check("cnt_1", 32'(bus.fifo_cnt), 32'd1);
    // Over-request pop at occupancy 1: only lane 0 pops.
    cycle(0, 2, 1'b0, 1'b0, 32'h0);
    check("cnt_0_after_pop", 32'(bus.fifo_cnt), 32'd0);
    check("vld_0_after_pop", 32'(bus.data_r_vld), 32'd0);

    // Flush with a full-width push: push refused, FIFO empty next cycle.
    cycle(3, 0, 1'b0, 1'b0, 32'h00333231);
    cycle(4, 0, 1'b1, 1'b0, 32'h44434241);
    check("flush_cnt",   32'(bus.fifo_cnt),   32'd0);
    check("flush_empty", 32'(bus.fifo_empty), 32'd1);
    cycle(0, 0, 1'b0, 1'b0, 32'h0);

    // RST mid-burst discards the in-flight push.
    cycle(2, 0, 1'b0, 1'b0, 32'h00005251);
    cycle(4, 0, 1'b0, 1'b1, 32'h64636261);
    RST = 1'b0;
    check("rst_cnt",   32'(bus.fifo_cnt),   32'd0);
    check("rst_vld",   32'(bus.data_r_vld), 32'd0);
    cycle(2, 1, 1'b0, 1'b0, 32'h00007271);
    cycle(0, 2, 1'b0, 1'b0, 32'h0);
    cycle(0, 0, 1'b0, 1'b0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
